// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage between the program counter and decode.
//   It issues instruction-memory reads at the current PC, returns the load
//   enable to the PC, and captures fetched words into the IF/ID register.
//   A one-entry skid buffer holds a memory hit that lands while decode is
//   stalled, so each instruction is fetched exactly once. Branch/jump flush
//   and halt are also handled here.
//
//   Optional build macro: FETCH_PERF_EN adds saturating fetch/stall counters.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   pc                   current PC from the program counter
//   pc_en                PC load enable (combinational)
//   iren, iaddr          instruction-memory read request and address (= pc)
//   ihit, iload          memory response valid and instruction word
//   id_stall             decode cannot accept an instruction this cycle
//   flush                control redirect; PC select already holds the target
//   halt                 HALT retired; stop fetching until reset
//   fetch_cnt/stall_cnt  performance counters (FETCH_PERF_EN only)
//   ifid_valid/instr/pc/npc  IF/ID pipeline register
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef FETCH_PERF_EN
   ,
   parameter int unsigned PERF_W    = 32
`endif
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [31:0]       pc,
   output logic              pc_en,
   output logic              iren,
   output logic [31:0]       iaddr,
   input  logic              ihit,
   input  logic [31:0]       iload,
   input  logic              id_stall,
   input  logic              flush,
   input  logic              halt,
`ifdef FETCH_PERF_EN
   output logic [PERF_W-1:0] fetch_cnt,
   output logic [PERF_W-1:0] stall_cnt,
`endif
   output logic              ifid_valid,
   output logic [31:0]       ifid_instr,
   output logic [31:0]       ifid_pc,
   output logic [31:0]       ifid_npc
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      SKID   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_q, state_d;

   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc_q,    buf_pc_d;
   logic [31:0] buf_npc_q,   buf_npc_d;

   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q,    ifid_pc_d;
   logic [31:0] ifid_npc_q,   ifid_npc_d;

   logic [31:0] npc;

   assign npc   = pc + 32'd4;
   assign iaddr = pc;

   always_comb begin
      state_d      = state_q;
      pc_en        = 1'b0;
      iren         = 1'b0;
      buf_instr_d  = buf_instr_q;
      buf_pc_d     = buf_pc_q;
      buf_npc_d    = buf_npc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_npc_d   = ifid_npc_q;

      unique case (state_q)
         FETCH: begin
            iren = 1'b1;
            if (halt) begin
               state_d      = HALTED;
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
            end else if (flush) begin
               // PC loads the redirect target; any same-cycle hit is dropped.
               pc_en        = 1'b1;
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
            end else if (ihit) begin
               pc_en = 1'b1;
               if (!id_stall) begin
                  ifid_valid_d = 1'b1;
                  ifid_instr_d = iload;
                  ifid_pc_d    = pc;
                  ifid_npc_d   = npc;
               end else begin
                  buf_instr_d = iload;
                  buf_pc_d    = pc;
                  buf_npc_d   = npc;
                  state_d     = SKID;
               end
            end else if (!id_stall) begin
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
            end
         end

         SKID: begin
            // The PC has already advanced past the buffered word, so no new
            // request is issued until the buffer drains.
            if (halt) begin
               state_d      = HALTED;
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
            end else if (flush) begin
               // Leaving SKID empties the buffer; its contents are dropped.
               pc_en        = 1'b1;
               ifid_valid_d = 1'b0;
               ifid_instr_d = NOP_INSTR;
               state_d      = FETCH;
            end else if (!id_stall) begin
               ifid_valid_d = 1'b1;
               ifid_instr_d = buf_instr_q;
               ifid_pc_d    = buf_pc_q;
               ifid_npc_d   = buf_npc_q;
               state_d      = FETCH;
            end
         end

         HALTED: begin
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= FETCH;
         buf_instr_q  <= '0;
         buf_pc_q     <= '0;
         buf_npc_q    <= '0;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= '0;
         ifid_npc_q   <= '0;
      end else begin
         state_q      <= state_d;
         buf_instr_q  <= buf_instr_d;
         buf_pc_q     <= buf_pc_d;
         buf_npc_q    <= buf_npc_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_npc_q   <= ifid_npc_d;
      end
   end

   assign ifid_valid = ifid_valid_q;
   assign ifid_instr = ifid_instr_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_npc   = ifid_npc_q;

`ifdef FETCH_PERF_EN
   logic              fetch_inc, stall_inc;
   logic [PERF_W-1:0] fetch_cnt_q, stall_cnt_q;

   // A valid IF/ID load comes either straight from memory or from the buffer.
   assign fetch_inc = !halt && !flush && !id_stall &&
                      ((state_q == FETCH && ihit) || state_q == SKID);
   assign stall_inc = (state_q == FETCH) && !ihit && !flush && !halt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (fetch_inc && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + PERF_W'(1);
         if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. Accepted fetches are pushed to a
//   scoreboard queue when driven and popped when IF/ID is expected to load.
//   Inputs change on the falling edge; combinational outputs are sampled 1ns
//   later and registered outputs 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] npc;
   } exp_t;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] iload = '0;
   logic        ihit = 1'b0, id_stall = 1'b0, flush = 1'b0, halt = 1'b0;
   logic        pc_en, iren, ifid_valid;
   logic [31:0] iaddr, ifid_instr, ifid_pc, ifid_npc;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt, stall_cnt;
   logic [31:0] f0, s0;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];
   exp_t e;

   always #5 CLK = ~CLK;

   fetch_unit #(
      .NOP_INSTR (NOP)
`ifdef FETCH_PERF_EN
      , .PERF_W  (32)
`endif
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .pc         (pc),
      .pc_en      (pc_en),
      .iren       (iren),
      .iaddr      (iaddr),
      .ihit       (ihit),
      .iload      (iload),
      .id_stall   (id_stall),
      .flush      (flush),
      .halt       (halt),
`ifdef FETCH_PERF_EN
      .fetch_cnt  (fetch_cnt),
      .stall_cnt  (stall_cnt),
`endif
      .ifid_valid (ifid_valid),
      .ifid_instr (ifid_instr),
      .ifid_pc    (ifid_pc),
      .ifid_npc   (ifid_npc)
   );

   // Applies one cycle's inputs just after the falling edge.
   task automatic drive(input logic h, input logic [31:0] ld, input logic st,
                        input logic fl, input logic hl);
      @(negedge CLK);
      ihit = h; iload = ld; id_stall = st; flush = fl; halt = hl;
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0; pc = '0;
      repeat (2) @(negedge CLK);
      #1;
      total++;
      if ({ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== {1'b0, NOP, 32'd0, 32'd0}) begin
         bad++;
         $display("FAIL reset_ifid: got %b %h %h %h want 0 %h 0 0",
                  ifid_valid, ifid_instr, ifid_pc, ifid_npc, NOP);
      end
      total++;
      if ({iren, iaddr} !== {1'b1, 32'd0}) begin
         bad++; $display("FAIL reset_iren: got %b %h want 1 0", iren, iaddr);
      end
`ifdef FETCH_PERF_EN
      total++;
      if ({fetch_cnt, stall_cnt} !== 64'd0) begin
         bad++; $display("FAIL reset_cnt: got %h %h want 0 0", fetch_cnt, stall_cnt);
      end
`endif
   endtask

   task automatic test_basic();
      @(negedge CLK);
      nRST = 1'b1; pc = 32'd0; ihit = 1'b1; iload = 32'h2408_000A; id_stall = 1'b0;
      sb.push_back('{32'h2408_000A, 32'd0, 32'd4});
      #1;
      total++;
      if ({pc_en, iren, iaddr} !== {1'b1, 1'b1, 32'd0}) begin
         bad++; $display("FAIL basic_req: got %b %b %h want 1 1 0", pc_en, iren, iaddr);
      end
      @(posedge CLK); #1;
      total++;
      if (sb.size() == 0) begin
         bad++; $display("FAIL basic_load: got empty scoreboard want entry");
      end else begin
         e = sb.pop_front();
         if ({ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== {1'b1, e.instr, e.pc, e.npc}) begin
            bad++;
            $display("FAIL basic_load: got %b %h %h %h want 1 %h %h %h",
                     ifid_valid, ifid_instr, ifid_pc, ifid_npc, e.instr, e.pc, e.npc);
         end
      end
      pc = 32'd4;
   endtask

   task automatic test_miss();
`ifdef FETCH_PERF_EN
      f0 = fetch_cnt; s0 = stall_cnt;
`endif
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
         total++;
         if ({pc_en, iren, iaddr} !== {1'b0, 1'b1, 32'd4}) begin
            bad++; $display("FAIL miss_req%0d: got %b %b %h want 0 1 4", i, pc_en, iren, iaddr);
         end
         @(posedge CLK); #1;
         total++;
         if ({ifid_valid, ifid_instr} !== {1'b0, NOP}) begin
            bad++; $display("FAIL miss_bubble%0d: got %b %h want 0 %h", i, ifid_valid, ifid_instr, NOP);
         end
      end
      sb.push_back('{32'h2009_0005, 32'd4, 32'd8});
      drive(1'b1, 32'h2009_0005, 1'b0, 1'b0, 1'b0);
      total++;
      if (pc_en !== 1'b1) begin
         bad++; $display("FAIL miss_hit_pcen: got %b want 1", pc_en);
      end
      @(posedge CLK); #1;
      total++;
      if (sb.size() == 0) begin
         bad++; $display("FAIL miss_load: got empty scoreboard want entry");
      end else begin
         e = sb.pop_front();
         if ({ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== {1'b1, e.instr, e.pc, e.npc}) begin
            bad++;
            $display("FAIL miss_load: got %b %h %h %h want 1 %h %h %h",
                     ifid_valid, ifid_instr, ifid_pc, ifid_npc, e.instr, e.pc, e.npc);
         end
      end
`ifdef FETCH_PERF_EN
      total++;
      if ({stall_cnt - s0, fetch_cnt - f0} !== {32'd3, 32'd1}) begin
         bad++; $display("FAIL miss_cnt: got stall+%0d fetch+%0d want stall+3 fetch+1",
                         stall_cnt - s0, fetch_cnt - f0);
      end
`endif
      pc = 32'd8;
   endtask

   task automatic test_skid();
      sb.push_back('{32'h8C22_0000, 32'd8, 32'd12});
      drive(1'b1, 32'h8C22_0000, 1'b1, 1'b0, 1'b0);
      total++;
      if ({pc_en, iren} !== 2'b11) begin
         bad++; $display("FAIL skid_accept: got %b %b want 1 1", pc_en, iren);
      end
      @(posedge CLK); #1;
      pc = 32'd12;
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== {1'b1, 32'h2009_0005, 32'd4, 32'd8}) begin
            bad++;
            $display("FAIL skid_hold%0d: got %b %h %h %h want 1 20090005 4 8",
                     i, ifid_valid, ifid_instr, ifid_pc, ifid_npc);
         end
         if (i == 0) begin
            drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
            total++;
            if ({pc_en, iren} !== 2'b00) begin
               bad++; $display("FAIL skid_idle: got %b %b want 0 0", pc_en, iren);
            end
            @(posedge CLK); #1;
         end
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({pc_en, iren} !== 2'b00) begin
         bad++; $display("FAIL skid_drain_pcen: got %b %b want 0 0", pc_en, iren);
      end
      @(posedge CLK); #1;
      total++;
      if (sb.size() == 0) begin
         bad++; $display("FAIL skid_load: got empty scoreboard want entry");
      end else begin
         e = sb.pop_front();
         if ({ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== {1'b1, e.instr, e.pc, e.npc}) begin
            bad++;
            $display("FAIL skid_load: got %b %h %h %h want 1 %h %h %h",
                     ifid_valid, ifid_instr, ifid_pc, ifid_npc, e.instr, e.pc, e.npc);
         end
      end
      drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      total++;
      if ({pc_en, iren, iaddr} !== {1'b0, 1'b1, 32'd12}) begin
         bad++; $display("FAIL skid_resume: got %b %b %h want 0 1 c", pc_en, iren, iaddr);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_flush();
      // Park a word in the skid buffer, then redirect.
      drive(1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
      @(posedge CLK); #1;
      pc = 32'd16;
      drive(1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0);
      total++;
      if ({pc_en, iren} !== 2'b10) begin
         bad++; $display("FAIL flush_skid_pcen: got %b %b want 1 0", pc_en, iren);
      end
      @(posedge CLK); #1;
      pc = 32'h100;
      total++;
      if ({ifid_valid, ifid_instr} !== {1'b0, NOP}) begin
         bad++; $display("FAIL flush_skid_bubble: got %b %h want 0 %h", ifid_valid, ifid_instr, NOP);
      end
      drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      total++;
      if ({pc_en, iren, iaddr} !== {1'b0, 1'b1, 32'h100}) begin
         bad++; $display("FAIL flush_target: got %b %b %h want 0 1 100", pc_en, iren, iaddr);
      end
      @(posedge CLK); #1;
      total++;
      if (ifid_valid !== 1'b0) begin
         bad++; $display("FAIL flush_buf_dropped: got %b want 0", ifid_valid);
      end
      // Flush in FETCH with a same-cycle hit: the hit must be discarded.
      drive(1'b1, 32'h3333_3333, 1'b0, 1'b1, 1'b0);
      total++;
      if (pc_en !== 1'b1) begin
         bad++; $display("FAIL flush_fetch_pcen: got %b want 1", pc_en);
      end
      @(posedge CLK); #1;
      pc = 32'h200;
      total++;
      if ({ifid_valid, ifid_instr} !== {1'b0, NOP}) begin
         bad++; $display("FAIL flush_fetch_bubble: got %b %h want 0 %h", ifid_valid, ifid_instr, NOP);
      end
      sb.push_back('{32'h4444_4444, 32'h200, 32'h204});
      drive(1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0);
      @(posedge CLK); #1;
      total++;
      if (sb.size() == 0) begin
         bad++; $display("FAIL flush_after_load: got empty scoreboard want entry");
      end else begin
         e = sb.pop_front();
         if ({ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== {1'b1, e.instr, e.pc, e.npc}) begin
            bad++;
            $display("FAIL flush_after_load: got %b %h %h %h want 1 %h %h %h",
                     ifid_valid, ifid_instr, ifid_pc, ifid_npc, e.instr, e.pc, e.npc);
         end
      end
      pc = 32'h204;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{32'hA000_0000 + 32'(i), pc, pc + 32'd4});
         drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
         total++;
         if ({pc_en, iaddr} !== {1'b1, pc}) begin
            bad++; $display("FAIL b2b_req%0d: got %b %h want 1 %h", i, pc_en, iaddr, pc);
         end
         @(posedge CLK); #1;
         total++;
         if (sb.size() == 0) begin
            bad++; $display("FAIL b2b_load%0d: got empty scoreboard want entry", i);
         end else begin
            e = sb.pop_front();
            if ({ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== {1'b1, e.instr, e.pc, e.npc}) begin
               bad++;
               $display("FAIL b2b_load%0d: got %b %h %h %h want 1 %h %h %h", i,
                        ifid_valid, ifid_instr, ifid_pc, ifid_npc, e.instr, e.pc, e.npc);
            end
         end
         pc = pc + 32'd4;
      end
   endtask

   task automatic test_wrap();
      @(negedge CLK);
      pc = 32'hFFFF_FFFC;
      sb.push_back('{32'h0BAD_F00D, 32'hFFFF_FFFC, 32'h0000_0000});
      drive(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
      @(posedge CLK); #1;
      total++;
      if (sb.size() == 0) begin
         bad++; $display("FAIL wrap_load: got empty scoreboard want entry");
      end else begin
         e = sb.pop_front();
         if ({ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== {1'b1, e.instr, e.pc, e.npc}) begin
            bad++;
            $display("FAIL wrap_load: got %b %h %h %h want 1 %h %h %h",
                     ifid_valid, ifid_instr, ifid_pc, ifid_npc, e.instr, e.pc, e.npc);
         end
      end
      pc = 32'd0;
   endtask

   task automatic test_halt();
      drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b1);
      total++;
      if (pc_en !== 1'b0) begin
         bad++; $display("FAIL halt_pcen: got %b want 0", pc_en);
      end
      @(posedge CLK); #1;
      total++;
      if ({ifid_valid, ifid_instr} !== {1'b0, NOP}) begin
         bad++; $display("FAIL halt_bubble: got %b %h want 0 %h", ifid_valid, ifid_instr, NOP);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h7000_0000 + 32'(i), i[0], i[1], 1'b0);
         total++;
         if ({pc_en, iren, ifid_valid} !== 3'b000) begin
            bad++; $display("FAIL halted%0d: got pc_en=%b iren=%b valid=%b want 0 0 0",
                            i, pc_en, iren, ifid_valid);
         end
         @(posedge CLK); #1;
      end
      total++;
      if ({ifid_valid, ifid_instr} !== {1'b0, NOP}) begin
         bad++; $display("FAIL halted_ifid: got %b %h want 0 %h", ifid_valid, ifid_instr, NOP);
      end
      @(negedge CLK);
      nRST = 1'b0; ihit = 1'b0; flush = 1'b0; id_stall = 1'b0; pc = 32'd0;
      #1;
`ifdef FETCH_PERF_EN
      total++;
      if ({fetch_cnt, stall_cnt} !== 64'd0) begin
         bad++; $display("FAIL halt_reset_cnt: got %h %h want 0 0", fetch_cnt, stall_cnt);
      end
`endif
      total++;
      if (iren !== 1'b1) begin
         bad++; $display("FAIL halt_reset_iren: got %b want 1", iren);
      end
      @(negedge CLK);
      nRST = 1'b1; ihit = 1'b1; iload = 32'h6666_6666;
      sb.push_back('{32'h6666_6666, 32'd0, 32'd4});
      #1;
      total++;
      if ({pc_en, iren} !== 2'b11) begin
         bad++; $display("FAIL halt_restart_req: got %b %b want 1 1", pc_en, iren);
      end
      @(posedge CLK); #1;
      total++;
      if (sb.size() == 0) begin
         bad++; $display("FAIL halt_restart_load: got empty scoreboard want entry");
      end else begin
         e = sb.pop_front();
         if ({ifid_valid, ifid_instr, ifid_pc, ifid_npc} !== {1'b1, e.instr, e.pc, e.npc}) begin
            bad++;
            $display("FAIL halt_restart_load: got %b %h %h %h want 1 %h %h %h",
                     ifid_valid, ifid_instr, ifid_pc, ifid_npc, e.instr, e.pc, e.npc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_miss();
      test_skid();
      test_flush();
      test_back_to_back();
      test_wrap();
      test_halt();
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
